// File: rtl/mem_arbiter_if.sv
// Fetch / load-store request channels plus the byte-wide RAM port seen by the arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_done_addr;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_done_addr, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_done_addr, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one byte-wide RAM; loads win ties,
// transactions are never preempted, and multi-byte accesses are serialized little-endian.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt, last, cap_idx;
  logic        hold, hold_nxt;
  logic [31:0] base, wdata, asm_q, asm_nxt;
  logic        start_if, start_mem, fin, cap, cool;
  logic        if_done_q, mem_done_q;
  logic [31:0] if_data_q, if_addr_q, mem_rdata_q;
  logic [31:0] ram_a_c;
  logic [7:0]  ram_dout_c;
  logic        ram_wr_c;

  // A done pulse blocks acceptance for that cycle so a still-held request is not re-issued.
  assign cool = if_done_q | mem_done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hold_nxt   = hold;
    start_if   = 1'b0;
    start_mem  = 1'b0;
    fin        = 1'b0;
    cap        = 1'b0;
    cap_idx    = cnt;
    ram_a_c    = '0;
    ram_wr_c   = 1'b0;
    ram_dout_c = '0;
    case (state)
      IDLE: begin
        if (!cool) begin
          if (bus.mem_req) begin
            start_mem = 1'b1;
            state_nxt = bus.mem_we ? MEM_WR : MEM_RD;
          end else if (bus.if_req) begin
            start_if  = 1'b1;
            state_nxt = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        ram_a_c = base + {30'd0, cnt};
        // RAM data lags the address by one cycle: the extra hold cycle catches the last byte.
        if (hold) begin
          cap       = 1'b1;
          fin       = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
          hold_nxt  = 1'b0;
        end else begin
          cap     = (cnt != 2'd0);
          cap_idx = cnt - 2'd1;
          if (cnt == last) hold_nxt = 1'b1;
          else             cnt_nxt  = cnt + 2'd1;
        end
      end
      MEM_WR: begin
        ram_a_c  = base + {30'd0, cnt};
        ram_wr_c = 1'b1;
        case (cnt)
          2'd0:    ram_dout_c = wdata[7:0];
          2'd1:    ram_dout_c = wdata[15:8];
          2'd2:    ram_dout_c = wdata[23:16];
          default: ram_dout_c = wdata[31:24];
        endcase
        if (cnt == last) begin
          fin       = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    asm_nxt = asm_q;
    if (cap) asm_nxt[{cap_idx, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      hold        <= 1'b0;
      last        <= '0;
      base        <= '0;
      wdata       <= '0;
      asm_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      if_addr_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      cnt        <= cnt_nxt;
      hold       <= hold_nxt;
      asm_q      <= asm_nxt;
      if_done_q  <= fin && (state == IF_RD);
      mem_done_q <= fin && (state != IF_RD);
      if (start_mem) begin
        base  <= bus.mem_addr;
        wdata <= bus.mem_wdata;
        asm_q <= '0;
        case (bus.mem_size)
          2'd0:    last <= 2'd0;
          2'd1:    last <= 2'd1;
          default: last <= 2'd3;
        endcase
      end
      if (start_if) begin
        base  <= bus.if_addr;
        asm_q <= '0;
        last  <= 2'd3;
      end
      if (fin && state == IF_RD) begin
        if_data_q <= asm_nxt;
        if_addr_q <= base;
      end
      if (fin && state == MEM_RD) mem_rdata_q <= asm_nxt;
    end
  end

  assign bus.if_done      = if_done_q;
  assign bus.if_done_addr = if_addr_q;
  assign bus.if_data      = if_data_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.ram_a        = ram_a_c;
  assign bus.ram_dout     = ram_dout_c;
  assign bus.ram_wr       = ram_wr_c;
endmodule
